branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the mispredict counter.
REQ-002 Ports: clk in 1, rising-edge clock; reset_n in 1, reset, asynchronous and active-low; one clock, one reset.
REQ-003 req_valid in 1, branch/jump request; req_ready out 1, block can accept.
REQ-004 req_func in 3, comparator function select {less, sign, negate}; req_jump in 1, unconditional (JAL/JALR); req_jalr in 1, register-relative target.
REQ-005 req_pc in 32, instruction PC; req_imm in 32, sign-extended offset; req_rs1 in 32 and req_rs2 in 32, operands; req_pred_taken in 1, fetch prediction.
REQ-006 cmp_a out 32, cmp_b out 32, cmp_func out 3: drive the shared comparator; cmp_result in 1, its combinational result.
REQ-007 redirect_valid out 1, redirect_ready in 1, redirect_pc out 32: fetch redirect handshake.
REQ-008 done_valid out 1, one-cycle completion pulse; done_taken out 1, resolved direction; done_link out 32, req_pc+4; done_misalign out 1, taken target not 4-byte aligned.
REQ-009 flush in 1, abort the in-flight request; mispredict_count out CNT_WIDTH, saturating count of redirects issued.

Function
REQ-010 FSM states IDLE, COMPARE, REDIRECT; req_ready SHALL be 1 only in IDLE with flush=0.
REQ-011 Accept on req_valid&req_ready: latch all req_* fields; next state COMPARE.
REQ-012 In COMPARE: cmp_a=latched rs1, cmp_b=latched rs2, cmp_func=latched func; outside COMPARE cmp_a, cmp_b and cmp_func SHALL be 0.
REQ-013 taken = jump ? 1 : cmp_result, sampled in COMPARE.
REQ-014 Target = jalr ? ((rs1+imm) & ~1) : (pc+imm), 32-bit modulo wrap; fallthrough = pc+4, modulo wrap.
REQ-015 misalign = taken & target[1]; on misalign, COMPARE SHALL assert done_valid with done_misalign=1, issue no redirect, leave the counter unchanged, then go to IDLE.
REQ-016 No misalign and taken==pred_taken: assert done_valid in the COMPARE cycle, then go to IDLE; latency SHALL be 1 cycle after accept.
REQ-017 No misalign and taken!=pred_taken: go to REDIRECT; redirect_pc = taken ? target : fallthrough.
REQ-018 On REDIRECT entry, increment mispredict_count, saturating at all-ones.
REQ-019 In REDIRECT: redirect_valid=1; redirect_pc SHALL stay stable until redirect_ready.
REQ-020 On redirect_valid&redirect_ready: done_valid pulses in the same cycle, then go to IDLE; the earliest handshake is 2 cycles after accept.
REQ-021 done_taken, done_link and done_misalign SHALL be valid only while done_valid=1, and 0 otherwise.
REQ-022 Flush in COMPARE or REDIRECT: return to IDLE on the next edge; suppress done_valid and redirect_valid in the flush cycle.
REQ-023 A counter increment already made before a flush SHALL stand.
REQ-024 Flush together with req_valid in IDLE: no accept.
REQ-025 Back-to-back operation: a new request is accepted in the first IDLE cycle after completion; no other bubbles.

Reset
REQ-026 reset_n=0 asynchronously forces IDLE, mispredict_count=0, and all outputs 0 except req_ready.
REQ-027 req_ready SHALL be 1 the first cycle after reset_n rises, with flush=0.
REQ-028 Reset mid-REDIRECT drops redirect_valid immediately; no done_valid pulse is produced.

Verification
REQ-029 BEQ: rs1=rs2=5, func=000, pc=0x100, imm=0x20, pred=0 -> cycle 2: redirect_valid, redirect_pc=0x120, count=1; ready high -> done_taken=1, done_link=0x104.
REQ-030 BNE predicted correctly: rs1=1, rs2=2, func=001, pred=1 -> done_valid 1 cycle after accept, done_taken=1, no redirect, count unchanged.
REQ-031 JALR: rs1=0x203, imm=0, pred=0 -> target 0x202, done_misalign=1, no redirect; same with rs1=0x201 -> redirect_pc=0x200.
REQ-032 BLTU vs BLT: rs1=0xFFFFFFFF, rs2=1; func=110 -> not taken; func=100 -> taken.
REQ-033 Backpressure and flush: hold redirect_ready=0 for 5 cycles -> redirect_pc stable; assert flush -> IDLE next cycle, no done_valid, count keeps its increment.
REQ-034 Saturation: CNT_WIDTH=2, 5 mispredicts -> count 3; async reset mid-COMPARE -> outputs 0 immediately.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: request, comparator, redirect and completion signals of branch_ctrl
interface branch_ctrl_if #(parameter int CNT_WIDTH = 16);
    logic                 req_valid, req_ready, req_jump, req_jalr, req_pred_taken;
    logic [2:0]           req_func;
    logic [31:0]          req_pc, req_imm, req_rs1, req_rs2;
    logic [31:0]          cmp_a, cmp_b;
    logic [2:0]           cmp_func;
    logic                 cmp_result;
    logic                 redirect_valid, redirect_ready;
    logic [31:0]          redirect_pc;
    logic                 done_valid, done_taken, done_misalign;
    logic [31:0]          done_link;
    logic                 flush;
    logic [CNT_WIDTH-1:0] mispredict_count;
    modport master (
        output req_valid, req_func, req_jump, req_jalr, req_pc, req_imm, req_rs1, req_rs2,
               req_pred_taken, cmp_result, redirect_ready, flush,
        input  req_ready, cmp_a, cmp_b, cmp_func, redirect_valid, redirect_pc,
               done_valid, done_taken, done_link, done_misalign, mispredict_count
    );
    modport slave (
        input  req_valid, req_func, req_jump, req_jalr, req_pc, req_imm, req_rs1, req_rs2,
               req_pred_taken, cmp_result, redirect_ready, flush,
        output req_ready, cmp_a, cmp_b, cmp_func, redirect_valid, redirect_pc,
               done_valid, done_taken, done_link, done_misalign, mispredict_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches/jumps on a shared comparator, redirects fetch on mispredict
module branch_ctrl #(parameter int CNT_WIDTH = 16) (
    input  logic          clk,
    input  logic          reset_n,
    branch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, REDIRECT} state_t;
    state_t               state, next;
    logic [31:0]          pc, imm, rs1, rs2, target, link;
    logic [2:0]           func;
    logic                 jump, jalr, pred, taken_q, taken, misalign, accept;
    logic [CNT_WIDTH-1:0] count;
    assign accept    = (state == IDLE) & bus.req_valid & ~bus.flush;
    assign taken     = jump | bus.cmp_result;
    assign target    = jalr ? ((rs1 + imm) & ~32'd1) : pc + imm;
    assign link      = pc + 32'd4;
    assign misalign  = taken & target[1];
    assign bus.req_ready        = (state == IDLE) & ~bus.flush;
    assign bus.cmp_a            = (state == COMPARE) ? rs1 : '0;
    assign bus.cmp_b            = (state == COMPARE) ? rs2 : '0;
    assign bus.cmp_func         = (state == COMPARE) ? func : '0;
    assign bus.redirect_valid   = (state == REDIRECT) & ~bus.flush;
    assign bus.redirect_pc      = (state == REDIRECT) ? (taken_q ? target : link) : '0;
    assign bus.mispredict_count = count;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {pc, imm, rs1, rs2, func, jump, jalr, pred, taken_q} <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                pc   <= bus.req_pc;
                imm  <= bus.req_imm;
                rs1  <= bus.req_rs1;
                rs2  <= bus.req_rs2;
                func <= bus.req_func;
                jump <= bus.req_jump;
                jalr <= bus.req_jalr;
                pred <= bus.req_pred_taken;
            end
            if (state == COMPARE) taken_q <= taken;
            if (state == COMPARE && next == REDIRECT && count != '1) count <= count + 1'b1;
        end
    end
    always_comb begin
        next              = state;
        bus.done_valid    = 1'b0;
        bus.done_taken    = 1'b0;
        bus.done_link     = '0;
        bus.done_misalign = 1'b0;
        case (state)
            IDLE: next = accept ? COMPARE : IDLE;
            COMPARE:
                if (bus.flush) next = IDLE;
                else if (misalign || taken == pred) begin
                    bus.done_valid    = 1'b1;
                    bus.done_taken    = taken;
                    bus.done_link     = link;
                    bus.done_misalign = misalign;
                    next              = IDLE;
                end else next = REDIRECT;
            REDIRECT:
                if (bus.flush) next = IDLE;
                else if (bus.redirect_ready) begin
                    bus.done_valid = 1'b1;
                    bus.done_taken = taken_q;
                    bus.done_link  = link;
                    next           = IDLE;
                end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors against a 16-bit and a 2-bit-counter instance
module tb_branch_ctrl;
    logic clk = 0, reset_n = 0;
    int   errors = 0, checks = 0;
    branch_ctrl_if #(.CNT_WIDTH(16)) m ();
    branch_ctrl_if #(.CNT_WIDTH(2))  s ();
    branch_ctrl #(.CNT_WIDTH(16)) u_dut (.clk(clk), .reset_n(reset_n), .bus(m));
    branch_ctrl #(.CNT_WIDTH(2))  u_sat (.clk(clk), .reset_n(reset_n), .bus(s));
    always #5 clk = ~clk;
    function automatic logic cmpf(input logic [31:0] a, b, input logic [2:0] f);
        return f[0] ^ (f[2] ? (f[1] ? a < b : $signed(a) < $signed(b)) : a == b);
    endfunction
    assign m.cmp_result     = cmpf(m.cmp_a, m.cmp_b, m.cmp_func);
    assign s.cmp_result     = cmpf(s.cmp_a, s.cmp_b, s.cmp_func);
    assign s.req_valid      = m.req_valid;
    assign s.req_func       = m.req_func;
    assign s.req_jump       = m.req_jump;
    assign s.req_jalr       = m.req_jalr;
    assign s.req_pc         = m.req_pc;
    assign s.req_imm        = m.req_imm;
    assign s.req_rs1        = m.req_rs1;
    assign s.req_rs2        = m.req_rs2;
    assign s.req_pred_taken = m.req_pred_taken;
    assign s.redirect_ready = m.redirect_ready;
    assign s.flush          = m.flush;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic issue(input logic [2:0] f, input logic j, jr, input logic [31:0] pc, imm, a, b, input logic p);
        @(negedge clk);
        m.req_valid = 1; m.req_func = f; m.req_jump = j; m.req_jalr = jr;
        m.req_pc = pc; m.req_imm = imm; m.req_rs1 = a; m.req_rs2 = b; m.req_pred_taken = p;
        #1 check("ready_accept", m.req_ready, 1);
        @(negedge clk);
        m.req_valid = 0;
        #1;
    endtask
    initial begin
        m.req_valid = 0; m.req_func = 0; m.req_jump = 0; m.req_jalr = 0; m.req_pc = 0;
        m.req_imm = 0; m.req_rs1 = 0; m.req_rs2 = 0; m.req_pred_taken = 0;
        m.redirect_ready = 1; m.flush = 0;
        #3;
        check("rst_ready", m.req_ready, 1);
        check("rst_redir", m.redirect_valid, 0);
        check("rst_done", m.done_valid, 0);
        check("rst_cnt", m.mispredict_count, 0);
        @(negedge clk) reset_n = 1;
        #1 check("post_rst_ready", m.req_ready, 1);
        issue(3'b000, 0, 0, 32'h100, 32'h20, 5, 5, 0);
        check("beq_cmp_a", m.cmp_a, 5);
        check("beq_cmp_b", m.cmp_b, 5);
        check("beq_cmp_func", m.cmp_func, 0);
        check("beq_cmp_done", m.done_valid, 0);
        check("beq_cmp_redir", m.redirect_valid, 0);
        step();
        check("beq_redir", m.redirect_valid, 1);
        check("beq_redir_pc", m.redirect_pc, 32'h120);
        check("beq_cnt", m.mispredict_count, 1);
        check("beq_sat_cnt", s.mispredict_count, 1);
        check("beq_done", m.done_valid, 1);
        check("beq_taken", m.done_taken, 1);
        check("beq_link", m.done_link, 32'h104);
        check("beq_misal", m.done_misalign, 0);
        step();
        check("idle_ready", m.req_ready, 1);
        check("idle_done", m.done_valid, 0);
        check("idle_link", m.done_link, 0);
        check("idle_cmp_a", m.cmp_a, 0);
        check("idle_redir_pc", m.redirect_pc, 0);
        issue(3'b001, 0, 0, 32'h200, 32'h40, 1, 2, 1);
        check("bne_done", m.done_valid, 1);
        check("bne_taken", m.done_taken, 1);
        check("bne_link", m.done_link, 32'h204);
        check("bne_redir", m.redirect_valid, 0);
        step();
        check("bne_cnt", m.mispredict_count, 1);
        check("bne_ready", m.req_ready, 1);
        issue(3'b000, 1, 1, 32'h300, 0, 32'h203, 0, 0);
        check("jalr_mis_done", m.done_valid, 1);
        check("jalr_mis_flag", m.done_misalign, 1);
        check("jalr_mis_taken", m.done_taken, 1);
        check("jalr_mis_redir", m.redirect_valid, 0);
        step();
        check("jalr_mis_cnt", m.mispredict_count, 1);
        issue(3'b000, 1, 1, 32'h300, 0, 32'h201, 0, 0);
        check("jalr_cmp_done", m.done_valid, 0);
        step();
        check("jalr_redir", m.redirect_valid, 1);
        check("jalr_redir_pc", m.redirect_pc, 32'h200);
        check("jalr_cnt", m.mispredict_count, 2);
        check("jalr_link", m.done_link, 32'h304);
        check("jalr_misal", m.done_misalign, 0);
        step();
        issue(3'b110, 0, 0, 32'h400, 32'h10, 32'hFFFF_FFFF, 1, 0);
        check("bltu_done", m.done_valid, 1);
        check("bltu_taken", m.done_taken, 0);
        check("bltu_link", m.done_link, 32'h404);
        step();
        issue(3'b100, 0, 0, 32'h400, 32'h10, 32'hFFFF_FFFF, 1, 1);
        check("blt_done", m.done_valid, 1);
        check("blt_taken", m.done_taken, 1);
        step();
        check("blt_cnt", m.mispredict_count, 2);
        m.redirect_ready = 0;
        issue(3'b000, 0, 0, 32'h500, 32'h80, 7, 7, 0);
        step();
        check("bp_cnt", m.mispredict_count, 3);
        check("bp_sat_cnt", s.mispredict_count, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp_redir", m.redirect_valid, 1);
            check("bp_pc", m.redirect_pc, 32'h580);
            check("bp_done", m.done_valid, 0);
            step();
        end
        m.flush = 1;
        #1;
        check("fl_redir", m.redirect_valid, 0);
        check("fl_done", m.done_valid, 0);
        check("fl_ready", m.req_ready, 0);
        @(negedge clk) m.flush = 0;
        #1;
        check("fl_idle_ready", m.req_ready, 1);
        check("fl_idle_redir", m.redirect_valid, 0);
        check("fl_cnt", m.mispredict_count, 3);
        m.redirect_ready = 1;
        @(negedge clk);
        m.flush = 1; m.req_valid = 1; m.req_rs1 = 32'h55;
        #1 check("fl_req_ready", m.req_ready, 0);
        @(negedge clk);
        m.flush = 0; m.req_valid = 0;
        #1;
        check("fl_req_noacc", m.cmp_a, 0);
        check("fl_req_idle", m.req_ready, 1);
        issue(3'b000, 0, 0, 32'h600, 32'h8, 3, 3, 0);
        m.flush = 1;
        #1 check("flc_done", m.done_valid, 0);
        @(negedge clk) m.flush = 0;
        #1;
        check("flc_cnt", m.mispredict_count, 3);
        check("flc_redir", m.redirect_valid, 0);
        for (int i = 0; i < 2; i++) begin
            issue(3'b000, 0, 0, 32'h700, 32'h4, 1, 1, 0);
            step();
            check("sat_done", m.done_valid, 1);
            step();
        end
        check("sat_full_cnt", m.mispredict_count, 5);
        check("sat_cnt", s.mispredict_count, 3);
        m.redirect_ready = 0;
        issue(3'b000, 0, 0, 32'h800, 32'h4, 2, 2, 0);
        step();
        check("rr_redir", m.redirect_valid, 1);
        reset_n = 0;
        #1;
        check("rr_redir_drop", m.redirect_valid, 0);
        check("rr_done", m.done_valid, 0);
        check("rr_cnt", m.mispredict_count, 0);
        @(negedge clk) reset_n = 1;
        #1 check("rr_ready", m.req_ready, 1);
        m.redirect_ready = 1;
        issue(3'b000, 0, 0, 32'h900, 32'h4, 9, 9, 1);
        check("rc_cmp_a", m.cmp_a, 9);
        reset_n = 0;
        #1;
        check("rc_cmp_a0", m.cmp_a, 0);
        check("rc_cmp_b0", m.cmp_b, 0);
        check("rc_done", m.done_valid, 0);
        check("rc_link", m.done_link, 0);
        check("rc_ready", m.req_ready, 1);
        @(negedge clk) reset_n = 1;
        #1 check("rc_post_ready", m.req_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
